// File: rtl/down_timer.sv
// down_timer: loadable down-counting timer with terminal-count pulse and optional auto-reload
//   clk, rst_n              clock, asynchronous active-low reset
//   load_valid/value/ready  start-value handshake, accepted only in IDLE
//   auto_reload             reload the start value at terminal count instead of stopping
//   enable, abort           decrement qualifier, stop the run without a terminal pulse
//   count_out, busy         registered count, high while running
//   tc_pulse, tc_count      one-cycle terminal strobe, terminal events since the last load
module down_timer #(
  parameter int WIDTH = 4,
  parameter int TCW = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_valid,
  input  logic [WIDTH-1:0] load_value,
  output logic             load_ready,
  input  logic             auto_reload,
  input  logic             enable,
  input  logic             abort,
  output logic [WIDTH-1:0] count_out,
  output logic             busy,
  output logic             tc_pulse,
  output logic [TCW-1:0]   tc_count
);
  typedef enum logic {IDLE, RUN} state_t;
  state_t state, state_nx;
  logic [WIDTH-1:0] reload_reg, reload_nx, count_nx;
  logic [TCW-1:0] tc_count_nx;
  logic tc_nx, load_go, term, zero_load;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      count_out <= '0;
      reload_reg <= '0;
      tc_pulse <= 1'b0;
      tc_count <= '0;
    end else begin
      state <= state_nx;
      count_out <= count_nx;
      reload_reg <= reload_nx;
      tc_pulse <= tc_nx;
      tc_count <= tc_count_nx;
    end
  // a zero start value terminates immediately without ever entering RUN
  always_comb begin
    load_go = load_valid && state == IDLE;
    zero_load = load_go && load_value == '0;
    term = state == RUN && !abort && enable && count_out == WIDTH'(1);
    state_nx = state == IDLE ? (load_go && !zero_load ? RUN : IDLE)
             : (abort || (term && !auto_reload)) ? IDLE : RUN;
    count_nx = load_go ? load_value
             : state == IDLE || !enable && !abort ? count_out
             : abort ? '0
             : term ? (auto_reload ? reload_reg : '0)
             : count_out - WIDTH'(1);
    reload_nx = load_go ? load_value : reload_reg;
    tc_nx = zero_load || term;
    tc_count_nx = zero_load ? TCW'(1) : load_go ? '0 : term ? tc_count + TCW'(1) : tc_count;
  end
  always_comb begin
    load_ready = state == IDLE;
    busy = state == RUN;
  end
endmodule

// File: tb/tb_down_timer.sv
// tb_down_timer: directed self-checking bench for down_timer
module tb_down_timer;
  logic clk = 1'b0, rst_n = 1'b0;
  logic load_valid = 1'b0, auto_reload = 1'b0, enable = 1'b0, abort = 1'b0;
  logic [3:0] load_value = '0;
  logic load_ready, busy, tc_pulse;
  logic [3:0] count_out;
  logic [7:0] tc_count;
  int passed = 0, total = 0;

  down_timer #(.WIDTH(4), .TCW(8)) dut (
    .clk(clk), .rst_n(rst_n), .load_valid(load_valid), .load_value(load_value),
    .load_ready(load_ready), .auto_reload(auto_reload), .enable(enable), .abort(abort),
    .count_out(count_out), .busy(busy), .tc_pulse(tc_pulse), .tc_count(tc_count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [3:0] n);
    load_valid = 1'b1;
    load_value = n;
    tick();
    load_valid = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    total++; if (count_out !== 4'd0) $display("FAIL reset_count got %0d exp 0", count_out); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL reset_busy got %b exp 0", busy); else passed++;
    total++; if (tc_pulse !== 1'b0) $display("FAIL reset_tc got %b exp 0", tc_pulse); else passed++;
    total++; if (tc_count !== 8'd0) $display("FAIL reset_tccount got %0d exp 0", tc_count); else passed++;
    total++; if (load_ready !== 1'b1) $display("FAIL reset_ready got %b exp 1", load_ready); else passed++;
    #12 rst_n = 1'b1;
    enable = 1'b1;
    abort = 1'b1;
    repeat (3) tick();
    abort = 1'b0;
    total++; if (count_out !== 4'd0 || busy !== 1'b0 || load_ready !== 1'b1)
      $display("FAIL reset_hold got count=%0d busy=%b ready=%b exp 0/0/1", count_out, busy, load_ready); else passed++;
  endtask

  task automatic test_one_shot();
    enable = 1'b1;
    auto_reload = 1'b0;
    do_load(4'd5);
    total++; if (count_out !== 4'd5 || busy !== 1'b1 || load_ready !== 1'b0 || tc_pulse !== 1'b0)
      $display("FAIL oneshot_load got count=%0d busy=%b ready=%b tc=%b exp 5/1/0/0", count_out, busy, load_ready, tc_pulse); else passed++;
    for (int i = 4; i >= 0; i--) begin
      tick();
      total++; if (count_out !== 4'(i) || tc_pulse !== (i == 0) || busy !== (i != 0) || load_ready !== (i == 0))
        $display("FAIL oneshot_step%0d got count=%0d tc=%b busy=%b ready=%b", i, count_out, tc_pulse, busy, load_ready); else passed++;
    end
    total++; if (tc_count !== 8'd1) $display("FAIL oneshot_tccount got %0d exp 1", tc_count); else passed++;
    tick();
    total++; if (tc_pulse !== 1'b0 || count_out !== 4'd0) $display("FAIL oneshot_after got tc=%b count=%0d exp 0/0", tc_pulse, count_out); else passed++;
  endtask

  task automatic test_periodic();
    logic [3:0] exp [9] = '{4'd2, 4'd1, 4'd3, 4'd2, 4'd1, 4'd3, 4'd2, 4'd1, 4'd3};
    enable = 1'b1;
    auto_reload = 1'b1;
    do_load(4'd3);
    total++; if (count_out !== 4'd3 || tc_count !== 8'd0) $display("FAIL periodic_load got count=%0d tccount=%0d exp 3/0", count_out, tc_count); else passed++;
    for (int i = 0; i < 9; i++) begin
      tick();
      total++; if (count_out !== exp[i] || tc_pulse !== (exp[i] == 4'd3) || busy !== 1'b1)
        $display("FAIL periodic_step%0d got count=%0d tc=%b busy=%b exp %0d/%b/1", i, count_out, tc_pulse, busy, exp[i], exp[i] == 4'd3); else passed++;
    end
    total++; if (tc_count !== 8'd3) $display("FAIL periodic_tccount got %0d exp 3", tc_count); else passed++;
    abort = 1'b1;
    tick();
    abort = 1'b0;
    auto_reload = 1'b0;
    total++; if (count_out !== 4'd0 || busy !== 1'b0 || tc_pulse !== 1'b0 || tc_count !== 8'd3)
      $display("FAIL periodic_abort got count=%0d busy=%b tc=%b tccount=%0d exp 0/0/0/3", count_out, busy, tc_pulse, tc_count); else passed++;
  endtask

  task automatic test_enable_abort();
    logic [3:0] exp [4] = '{4'd3, 4'd3, 4'd3, 4'd2};
    logic en [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    enable = 1'b1;
    do_load(4'd4);
    total++; if (count_out !== 4'd4) $display("FAIL gate_load got %0d exp 4", count_out); else passed++;
    for (int i = 0; i < 4; i++) begin
      enable = en[i];
      tick();
      total++; if (count_out !== exp[i] || busy !== 1'b1) $display("FAIL gate_step%0d got count=%0d busy=%b exp %0d/1", i, count_out, busy, exp[i]); else passed++;
    end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    total++; if (count_out !== 4'd0 || busy !== 1'b0 || load_ready !== 1'b1 || tc_pulse !== 1'b0 || tc_count !== 8'd0)
      $display("FAIL gate_abort got count=%0d busy=%b ready=%b tc=%b tccount=%0d exp 0/0/1/0/0", count_out, busy, load_ready, tc_pulse, tc_count); else passed++;
  endtask

  task automatic test_edges();
    enable = 1'b1;
    do_load(4'd0);
    total++; if (count_out !== 4'd0 || tc_pulse !== 1'b1 || busy !== 1'b0 || tc_count !== 8'd1 || load_ready !== 1'b1)
      $display("FAIL zero_load got count=%0d tc=%b busy=%b tccount=%0d ready=%b exp 0/1/0/1/1", count_out, tc_pulse, busy, tc_count, load_ready); else passed++;
    tick();
    total++; if (tc_pulse !== 1'b0 || tc_count !== 8'd1) $display("FAIL zero_after got tc=%b tccount=%0d exp 0/1", tc_pulse, tc_count); else passed++;
    do_load(4'd15);
    repeat (14) tick();
    total++; if (count_out !== 4'd1 || tc_pulse !== 1'b0 || busy !== 1'b1) $display("FAIL max_pre got count=%0d tc=%b busy=%b exp 1/0/1", count_out, tc_pulse, busy); else passed++;
    tick();
    total++; if (count_out !== 4'd0 || tc_pulse !== 1'b1 || busy !== 1'b0 || tc_count !== 8'd1)
      $display("FAIL max_term got count=%0d tc=%b busy=%b tccount=%0d exp 0/1/0/1", count_out, tc_pulse, busy, tc_count); else passed++;
    do_load(4'd2);
    load_valid = 1'b1;
    load_value = 4'd7;
    tick();
    total++; if (count_out !== 4'd1 || busy !== 1'b1) $display("FAIL held_run got count=%0d busy=%b exp 1/1", count_out, busy); else passed++;
    tick();
    total++; if (count_out !== 4'd0 || tc_pulse !== 1'b1 || load_ready !== 1'b1) $display("FAIL held_term got count=%0d tc=%b ready=%b exp 0/1/1", count_out, tc_pulse, load_ready); else passed++;
    tick();
    load_valid = 1'b0;
    total++; if (count_out !== 4'd7 || busy !== 1'b1 || tc_count !== 8'd0 || tc_pulse !== 1'b0)
      $display("FAIL held_capture got count=%0d busy=%b tccount=%0d tc=%b exp 7/1/0/0", count_out, busy, tc_count, tc_pulse); else passed++;
    abort = 1'b1;
    tick();
    abort = 1'b0;
  endtask

  task automatic test_async_reset();
    enable = 1'b1;
    do_load(4'd9);
    repeat (4) tick();
    total++; if (count_out !== 4'd5) $display("FAIL async_pre got %0d exp 5", count_out); else passed++;
    #2 rst_n = 1'b0;
    #1;
    total++; if (count_out !== 4'd0 || busy !== 1'b0 || tc_pulse !== 1'b0 || tc_count !== 8'd0 || load_ready !== 1'b1)
      $display("FAIL async_clear got count=%0d busy=%b tc=%b tccount=%0d ready=%b exp 0/0/0/0/1", count_out, busy, tc_pulse, tc_count, load_ready); else passed++;
    tick();
    rst_n = 1'b1;
    repeat (2) tick();
    total++; if (count_out !== 4'd0 || busy !== 1'b0 || tc_pulse !== 1'b0)
      $display("FAIL async_hold got count=%0d busy=%b tc=%b exp 0/0/0", count_out, busy, tc_pulse); else passed++;
  endtask

  initial begin
    test_reset();
    test_one_shot();
    test_periodic();
    test_enable_abort();
    test_edges();
    test_async_reset();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
